spi_config_ctrl: RTL and testbench

// - SPI slave (mode 0) that decodes config frames and drives the SPI-side inputs of the pixel config mux:

---
 rtl/pixcfg_pkg.sv | 25 ++
 rtl/spi_pin_sync.sv | 38 +++
 rtl/spi_config_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_spi_config_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixcfg_pkg.sv
// Shared opcodes, widths and state encodings for the SPI pixel-config controller.
package pixcfg_pkg;

    localparam int CFG_W  = 24;
    localparam int HALF_W = 2;

    localparam logic [3:0] OP_LOAD = 4'h1;
    localparam logic [3:0] OP_SHUT = 4'h2;
    localparam logic [3:0] OP_MODE = 4'h3;
    localparam logic [3:0] OP_READ = 4'h4;
    localparam logic [3:0] OP_CLR  = 4'h5;

    typedef enum logic [1:0] {F_IDLE, F_CMD, F_DATA, F_DONE} frame_state_t;
    typedef enum logic [1:0] {P_IDLE, P_SETUP, P_HIGH, P_HOLD} push_state_t;

    // Payload length in bits following the command byte; 0 means none is consumed.
    function automatic logic [4:0] payload_bits(input logic [3:0] op);
        case (op)
            OP_LOAD, OP_READ: payload_bits = 5'd24;
            OP_SHUT, OP_MODE: payload_bits = 5'd8;
            default:          payload_bits = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronisers for the SPI pins plus edge detection on the synced copies.
module spi_pin_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sclk,
    input  logic i_cs_n,
    input  logic i_mosi,
    output logic o_sclk_rise,
    output logic o_sclk_fall,
    output logic o_cs_fall,
    output logic o_cs_rise,
    output logic o_mosi
);

    logic [2:0] r_sclk;
    logic [2:0] r_cs_n;
    logic [1:0] r_mosi;

    // cs_n resets to its inactive level so reset release never looks like a frame start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sclk <= 3'b000;
            r_cs_n <= 3'b111;
            r_mosi <= 2'b00;
        end else begin
            r_sclk <= {r_sclk[1:0], i_sclk};
            r_cs_n <= {r_cs_n[1:0], i_cs_n};
            r_mosi <= {r_mosi[0], i_mosi};
        end
    end

    assign o_sclk_rise = r_sclk[1] & ~r_sclk[2];
    assign o_sclk_fall = ~r_sclk[1] & r_sclk[2];
    assign o_cs_fall   = ~r_cs_n[1] & r_cs_n[2];
    assign o_cs_rise   = r_cs_n[1] & ~r_cs_n[2];
    assign o_mosi      = r_mosi[1];

endmodule

// File: rtl/spi_config_ctrl.sv
// SPI mode-0 slave decoding config frames; drives the SPI side of the pixel config mux
// and sequences the setup / push / hold strobe for per-pixel config words.
module spi_config_ctrl
    import pixcfg_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int PUSH_W    = 4,
    parameter int HOLD_CYC  = 2
) (
    input  logic              clk_40MHz,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [CFG_W-1:0]  config_info_spi_0,
    output logic [HALF_W-1:0] push_clk_spi,
    output logic [HALF_W-1:0] shutter_output_spi,
    output logic [HALF_W-1:0] mode_output_spi,
    output logic              busy,
    output logic              err_sticky
);

    localparam int MAX_SP  = (SETUP_CYC > PUSH_W) ? SETUP_CYC : PUSH_W;
    localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise, w_mosi;

    spi_pin_sync u_sync (
        .i_clk       (clk_40MHz),
        .i_rst_n     (rst_n),
        .i_sclk      (spi_sclk),
        .i_cs_n      (spi_cs_n),
        .i_mosi      (spi_mosi),
        .o_sclk_rise (w_sclk_rise),
        .o_sclk_fall (w_sclk_fall),
        .o_cs_fall   (w_cs_fall),
        .o_cs_rise   (w_cs_rise),
        .o_mosi      (w_mosi)
    );

    frame_state_t      r_fstate, w_fstate_next;
    push_state_t       r_pstate, w_pstate_next;
    logic [4:0]        r_bit_cnt;
    logic [CFG_W-1:0]  r_shift, w_shift_next;
    logic [CFG_W-1:0]  r_cfg, r_miso_sh;
    logic [3:0]        r_op;
    logic [HALF_W-1:0] r_mask, r_push_mask, r_shut, r_mode;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic              r_miso, r_err;
    logic [3:0]        w_cmd_op;
    logic              w_cmd_done, w_pay_done, w_load_done, w_busy, w_push_start;

    assign w_shift_next = {r_shift[CFG_W-2:0], w_mosi};
    assign w_cmd_op     = w_shift_next[7:4];
    assign w_cmd_done   = (r_fstate == F_CMD) && w_sclk_rise && (r_bit_cnt == 5'd7);
    assign w_pay_done   = (r_fstate == F_DATA) && w_sclk_rise &&
                          (r_bit_cnt == payload_bits(r_op) - 5'd1);
    assign w_load_done  = w_pay_done && (r_op == OP_LOAD);
    assign w_busy       = (r_pstate != P_IDLE);
    assign w_push_start = w_load_done && !w_busy;

    always_comb begin
        w_fstate_next = r_fstate;
        case (r_fstate)
            F_IDLE: if (w_cs_fall) w_fstate_next = F_CMD;
            F_CMD: begin
                if (w_cs_rise)
                    w_fstate_next = F_IDLE;
                else if (w_cmd_done)
                    w_fstate_next = (payload_bits(w_cmd_op) == 5'd0) ? F_DONE : F_DATA;
            end
            F_DATA: begin
                if (w_cs_rise)       w_fstate_next = F_IDLE;
                else if (w_pay_done) w_fstate_next = F_DONE;
            end
            F_DONE: if (w_cs_rise) w_fstate_next = F_IDLE;
            default: w_fstate_next = F_IDLE;
        endcase
    end

    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_fstate  <= F_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_op      <= '0;
            r_mask    <= '0;
            r_shut    <= '0;
            r_mode    <= '0;
            r_err     <= 1'b0;
            r_miso    <= 1'b0;
            r_miso_sh <= '0;
        end else begin
            r_fstate <= w_fstate_next;
            if (w_fstate_next != r_fstate)
                r_bit_cnt <= '0;
            else if (w_sclk_rise && (r_fstate == F_CMD || r_fstate == F_DATA))
                r_bit_cnt <= r_bit_cnt + 5'd1;
            if (w_sclk_rise)
                r_shift <= w_shift_next;
            if (w_cmd_done) begin
                r_op   <= w_cmd_op;
                r_mask <= w_shift_next[HALF_W-1:0];
            end
            if (w_cmd_done && w_cmd_op == OP_CLR)
                r_err <= 1'b0;
            else if (w_load_done && w_busy)
                r_err <= 1'b1;
            if (w_pay_done && r_op == OP_SHUT)
                r_shut <= w_shift_next[HALF_W-1:0];
            if (w_pay_done && r_op == OP_MODE)
                r_mode <= w_shift_next[HALF_W-1:0];
            // Readback snapshot is taken at the end of the command byte; bits leave on falling sclk.
            if (w_cmd_done && w_cmd_op == OP_READ)
                r_miso_sh <= r_cfg;
            if (r_fstate == F_DATA && r_op == OP_READ) begin
                if (w_sclk_fall) begin
                    r_miso    <= r_miso_sh[CFG_W-1];
                    r_miso_sh <= {r_miso_sh[CFG_W-2:0], 1'b0};
                end
            end else begin
                r_miso <= 1'b0;
            end
        end
    end

    always_comb begin
        w_pstate_next = r_pstate;
        w_cnt_next    = r_cnt;
        case (r_pstate)
            P_IDLE: begin
                if (w_push_start) begin
                    w_pstate_next = P_SETUP;
                    w_cnt_next    = CNT_W'(SETUP_CYC - 1);
                end
            end
            P_SETUP: begin
                if (r_cnt == '0) begin
                    w_pstate_next = P_HIGH;
                    w_cnt_next    = CNT_W'(PUSH_W - 1);
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            P_HIGH: begin
                if (r_cnt == '0) begin
                    w_pstate_next = P_HOLD;
                    w_cnt_next    = CNT_W'(HOLD_CYC - 1);
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            P_HOLD: begin
                if (r_cnt == '0) w_pstate_next = P_IDLE;
                else             w_cnt_next    = r_cnt - CNT_W'(1);
            end
            default: w_pstate_next = P_IDLE;
        endcase
    end

    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_pstate    <= P_IDLE;
            r_cnt       <= '0;
            r_cfg       <= '0;
            r_push_mask <= '0;
        end else begin
            r_pstate <= w_pstate_next;
            r_cnt    <= w_cnt_next;
            if (w_push_start) begin
                r_cfg       <= w_shift_next;
                r_push_mask <= r_mask;
            end
        end
    end

    // Decoded from the state register so an async reset drops the strobe immediately.
    assign push_clk_spi       = (r_pstate == P_HIGH) ? r_push_mask : '0;
    assign busy               = w_busy;
    assign config_info_spi_0  = r_cfg;
    assign shutter_output_spi = r_shut;
    assign mode_output_spi    = r_mode;
    assign err_sticky         = r_err;
    assign spi_miso           = r_miso;

endmodule

// File: tb/tb_spi_config_ctrl.sv
// Randomised scoreboard bench for spi_config_ctrl: a frame-level model queues expected
// output events, and monitors pop and compare them as the DUT outputs change.
`timescale 1ns/1ps
module tb_spi_config_ctrl;

    localparam int SETUP_CYC = 2;
    localparam int PUSH_W    = 4;
    localparam int HOLD_CYC  = 2;
    localparam int E_PUSH_W  = 2000;

    logic        clk, rst_n, sclk, cs_n, cs_e_n, mosi;
    logic        miso, busy, err, miso_e, busy_e, err_e;
    logic [23:0] cfg, cfg_e;
    logic [1:0]  push, shut, mode, push_e, shut_e, mode_e;

    spi_config_ctrl dut (
        .clk_40MHz(clk), .rst_n(rst_n), .spi_sclk(sclk), .spi_cs_n(cs_n), .spi_mosi(mosi),
        .spi_miso(miso), .config_info_spi_0(cfg), .push_clk_spi(push),
        .shutter_output_spi(shut), .mode_output_spi(mode), .busy(busy), .err_sticky(err)
    );

    // Second instance with a very long push so a full LOAD frame can complete while busy.
    spi_config_ctrl #(.PUSH_W(E_PUSH_W)) dut_e (
        .clk_40MHz(clk), .rst_n(rst_n), .spi_sclk(sclk), .spi_cs_n(cs_e_n), .spi_mosi(mosi),
        .spi_miso(miso_e), .config_info_spi_0(cfg_e), .push_clk_spi(push_e),
        .shutter_output_spi(shut_e), .mode_output_spi(mode_e), .busy(busy_e), .err_sticky(err_e)
    );

    initial clk = 1'b0;
    always #12.5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [23:0] q_cfg[$], q_read[$], q_cfg_e[$];
    logic [1:0]  q_shut[$], q_mode[$];
    logic [31:0] q_busy[$];
    logic        q_err_e[$];

    logic [23:0] m_cfg;
    logic [1:0]  m_shut, m_mode;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected change to %h, expected no event", name, act);
    endtask

    function automatic logic [31:0] busy_key(input int len, input int pcyc, input int first,
                                             input logic stable, input logic [1:0] por);
        return {8'(len), 8'(pcyc), 8'(first), 5'd0, stable, por};
    endfunction

    // Frame-level reference: what each complete frame must do to the outputs.
    task automatic model_frame(input logic [31:0] b, input int nb);
        logic [3:0] op;
        logic [1:0] m;
        op = b[31:28];
        m  = b[25:24];
        case (op)
            4'h1: if (nb >= 32) begin
                if (b[23:0] != m_cfg) q_cfg.push_back(b[23:0]);
                m_cfg = b[23:0];
                q_busy.push_back(busy_key(SETUP_CYC + PUSH_W + HOLD_CYC,
                                          (m == 2'b00) ? 0 : PUSH_W,
                                          (m == 2'b00) ? -1 : SETUP_CYC, 1'b1, m));
            end
            4'h2: if (nb >= 16) begin
                if (b[17:16] != m_shut) q_shut.push_back(b[17:16]);
                m_shut = b[17:16];
            end
            4'h3: if (nb >= 16) begin
                if (b[17:16] != m_mode) q_mode.push_back(b[17:16]);
                m_mode = b[17:16];
            end
            4'h4: if (nb >= 32) q_read.push_back(m_cfg);
            default: ;
        endcase
    endtask

    task automatic spi_frame(input logic to_e, input logic [31:0] b, input int nb);
        @(negedge clk);
        #3;
        if (to_e) cs_e_n = 1'b0;
        else      cs_n   = 1'b0;
        for (int i = 0; i < nb; i++) begin
            mosi = b[31-i];
            #200 sclk = 1'b1;
            #200 sclk = 1'b0;
        end
        mosi = 1'b0;
        #200;
        cs_n   = 1'b1;
        cs_e_n = 1'b1;
        #200;
    endtask

    task automatic do_frame(input logic [31:0] b, input int nb);
        $display("frame %h bits=%0d", b, nb);
        model_frame(b, nb);
        spi_frame(1'b0, b, nb);
    endtask

    // Output-change monitor for the main instance.
    initial begin : mon_main
        logic [23:0] p_cfg;
        logic [1:0]  p_shut, p_mode;
        logic        p_err, p_busy, b_stable;
        logic [1:0]  b_por;
        int          b_len, b_pcyc, b_first;
        p_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                p_cfg = cfg; p_shut = shut; p_mode = mode; p_err = err; p_busy = 1'b0;
                continue;
            end
            if (cfg !== p_cfg) begin
                if (p_busy && busy) b_stable = 1'b0;
                if (q_cfg.size() == 0) unexpected("cfg", 32'(cfg));
                else check("cfg", 32'(cfg), 32'(q_cfg.pop_front()));
            end
            if (shut !== p_shut) begin
                if (q_shut.size() == 0) unexpected("shutter", 32'(shut));
                else check("shutter", 32'(shut), 32'(q_shut.pop_front()));
            end
            if (mode !== p_mode) begin
                if (q_mode.size() == 0) unexpected("mode", 32'(mode));
                else check("mode", 32'(mode), 32'(q_mode.pop_front()));
            end
            if (err !== p_err) unexpected("err_main", 32'(err));
            if (!busy && push !== 2'b00) unexpected("push_idle", 32'(push));
            if (busy) begin
                if (!p_busy) begin
                    b_len = 0; b_pcyc = 0; b_first = -1; b_por = 2'b00; b_stable = 1'b1;
                end
                if (push !== 2'b00) begin
                    if (b_first < 0) b_first = b_len;
                    b_pcyc++;
                    b_por |= push;
                end
                b_len++;
            end else if (p_busy) begin
                if (q_busy.size() == 0)
                    unexpected("busy_seq", busy_key(b_len, b_pcyc, b_first, b_stable, b_por));
                else
                    check("busy_seq", busy_key(b_len, b_pcyc, b_first, b_stable, b_por),
                          q_busy.pop_front());
            end
            p_cfg = cfg; p_shut = shut; p_mode = mode; p_err = err; p_busy = busy;
        end
    end

    // Pin-level monitor: captures MOSI/MISO on rising sclk for each main-instance frame.
    initial begin : mon_spi
        logic [31:0] mo, mi;
        logic        early;
        int          cnt;
        forever begin
            @(negedge cs_n);
            cnt = 0; mo = '0; mi = '0; early = 1'b0;
            while (cs_n === 1'b0) begin
                @(posedge sclk or posedge cs_n);
                if (cs_n === 1'b0 && sclk === 1'b1) begin
                    if (cnt < 8 && miso !== 1'b0) early = 1'b1;
                    mo = {mo[30:0], mosi};
                    mi = {mi[30:0], miso};
                    cnt++;
                end
            end
            if (rst_n === 1'b1 && cnt >= 8) check("miso_cmd_quiet", 32'(early), 32'd0);
            if (cnt == 32 && mo[31:28] == 4'h4) begin
                if (q_read.size() == 0) unexpected("read", mi);
                else check("read", 32'(mi[23:0]), 32'(q_read.pop_front()));
            end
        end
    end

    initial begin : mon_e
        logic [23:0] p_cfg;
        logic        p_err;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                p_cfg = cfg_e; p_err = err_e;
                continue;
            end
            if (cfg_e !== p_cfg) begin
                if (q_cfg_e.size() == 0) unexpected("cfg_e", 32'(cfg_e));
                else check("cfg_e", 32'(cfg_e), 32'(q_cfg_e.pop_front()));
            end
            if (err_e !== p_err) begin
                if (q_err_e.size() == 0) unexpected("err_e", 32'(err_e));
                else check("err_e", 32'(err_e), 32'(q_err_e.pop_front()));
            end
            p_cfg = cfg_e; p_err = err_e;
        end
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [3:0]  ops [8];
        logic [31:0] r, b;
        logic [3:0]  op;
        int          full, nb, k;
        ops = '{4'h1, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hF};
        rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; cs_e_n = 1'b1; mosi = 1'b0;
        m_cfg = '0; m_shut = '0; m_mode = '0;
        repeat (5) @(negedge clk);
        check("rst_cfg",   32'(cfg),  32'd0);
        check("rst_push",  32'(push), 32'd0);
        check("rst_shut",  32'(shut), 32'd0);
        check("rst_mode",  32'(mode), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_err",   32'(err),  32'd0);
        check("rst_miso",  32'(miso), 32'd0);
        #3 rst_n = 1'b1;
        repeat (5) @(negedge clk);

        do_frame(32'h13A53C0F, 32);
        do_frame(32'h20020000, 16);
        do_frame(32'h30010000, 16);
        do_frame(32'h11123456, 32);
        do_frame(32'h40000000, 32);
        do_frame(32'h13FFFFFF, 12);
        do_frame(32'h12ABCDEF, 32);

        for (int i = 0; i < 30; i++) begin
            r  = $urandom();
            op = ops[r[2:0]];
            full = 8 + ((op == 4'h1 || op == 4'h4) ? 24 : (op == 4'h2 || op == 4'h3) ? 8 : 0);
            b = {op, r[7:4], 24'($urandom())};
            if ($urandom_range(0, 9) < 2) nb = $urandom_range(1, full - 1);
            else                         nb = $urandom_range(full, 32);
            do_frame(b, nb);
        end

        // Second LOAD completes while the long push is running and must be dropped.
        q_cfg_e.push_back(24'hA53C0F);
        spi_frame(1'b1, 32'h13A53C0F, 32);
        q_err_e.push_back(1'b1);
        spi_frame(1'b1, 32'h12111111, 32);
        check("busy_e_during_second_load", 32'(busy_e), 32'd1);
        k = 0;
        while (busy_e === 1'b1 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("busy_e_ends", 32'(k < 5000), 32'd1);
        q_err_e.push_back(1'b0);
        spi_frame(1'b1, 32'h50000000, 8);

        // Asynchronous reset in the middle of the push pulse.
        do_frame(32'h20030000, 16);
        do_frame(32'h30020000, 16);
        if (m_cfg != 24'h5AF00F) q_cfg.push_back(24'h5AF00F);
        fork
            spi_frame(1'b0, 32'h135AF00F, 32);
            begin
                k = 0;
                while (push === 2'b00 && k < 3000) begin
                    @(negedge clk);
                    k++;
                end
                check("push_seen_before_reset", 32'(k < 3000), 32'd1);
                #3 rst_n = 1'b0;
                #1;
                check("arst_push", 32'(push), 32'd0);
                check("arst_cfg",  32'(cfg),  32'd0);
                check("arst_shut", 32'(shut), 32'd0);
                check("arst_mode", 32'(mode), 32'd0);
                check("arst_busy", 32'(busy), 32'd0);
                wait (cs_n === 1'b1);
                repeat (4) @(negedge clk);
                #3 rst_n = 1'b1;
            end
        join
        m_cfg = '0; m_shut = '0; m_mode = '0;
        repeat (5) @(negedge clk);
        do_frame(32'h40000000, 32);

        repeat (50) @(negedge clk);
        check("left_cfg",   32'(q_cfg.size()),   32'd0);
        check("left_shut",  32'(q_shut.size()),  32'd0);
        check("left_mode",  32'(q_mode.size()),  32'd0);
        check("left_busy",  32'(q_busy.size()),  32'd0);
        check("left_read",  32'(q_read.size()),  32'd0);
        check("left_cfg_e", 32'(q_cfg_e.size()), 32'd0);
        check("left_err_e", 32'(q_err_e.size()), 32'd0);
        check("e_quiet_outputs", {26'd0, shut_e, mode_e, push_e}, 32'd0);
        check("e_miso_idle", 32'(miso_e), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
